// File: rtl/sb_pkg.sv
// Shared types and sizing for the posted-write store buffer.
// Every file that uses the buffer entry type imports this package.
package sb_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_AW    = 32;
  localparam int SB_DW    = 32;
  localparam int PTR_W    = $clog2(SB_DEPTH);

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_fwd.sv
// Store-to-load forwarding: a combinational match of the load's word address
// against the valid buffered stores. When more than one store matches, the youngest one wins.
module store_buffer_fwd
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW,
  parameter int PW    = PTR_W
) (
  input  sb_entry_t        i_entry [DEPTH],
  input  logic [DEPTH-1:0] i_valid,
  input  logic [PW-1:0]    i_tail,
  input  logic [AW-3:0]    i_word_addr,
  output logic             o_hit,
  output logic [DW-1:0]    o_hit_data
);

  logic [PW-1:0] w_idx;
  logic          w_unused_addr_lo;

  // Walk from oldest to youngest and overwrite on every match.
  // The last match written is the youngest store.
  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    o_hit            = 1'b0;
    o_hit_data       = '0;
    w_idx            = '0;
    w_unused_addr_lo = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_idx = i_tail - PW'(k + 1);
      if (i_valid[w_idx] && (i_entry[w_idx].addr[AW-1:2] == i_word_addr)) begin
        o_hit      = 1'b1;
        o_hit_data = i_entry[w_idx].data;
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      w_unused_addr_lo = w_unused_addr_lo ^ (^i_entry[k].addr[1:0]);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between the core's data port and a possibly slow data memory.
// Stores retire in one cycle, drain over a req/ack handshake, and are forwarded to loads.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cpu_we,
  input  logic [AW-1:0]              cpu_addr,
  input  logic [DW-1:0]              cpu_wdata,
  output logic [DW-1:0]              cpu_rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       mem_req,
  output logic [AW-1:0]              mem_addr,
  output logic [DW-1:0]              mem_wdata,
  input  logic                       mem_ack,
  input  logic [DW-1:0]              mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  sb_entry_t        r_entry [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_head;
  logic [PW-1:0]    r_tail;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_hit;
  logic [DW-1:0]    w_hit_data;

  // Flags decode from registered state only, so mem_req cannot glitch.
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = cpu_we & ~w_full;
  assign w_pop   = ~w_empty & mem_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (cpu_we && w_full) r_overflow <= 1'b1;
    end
  end

  // A push and a pop never address the same slot.
  // Pushing needs a free slot, and popping needs a valid one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the entry array is reset on purpose so that mem_addr/mem_wdata read 0 out of reset.
      for (int i = 0; i < DEPTH; i++) r_entry[i] <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop) r_valid[r_head] <= 1'b0;
      if (w_push) begin
        r_valid[r_tail]      <= 1'b1;
        r_entry[r_tail].addr <= cpu_addr;
        r_entry[r_tail].data <= cpu_wdata;
      end
    end
  end

  store_buffer_fwd #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW),
    .PW    (PW)
  ) u_fwd (
    .i_entry     (r_entry),
    .i_valid     (r_valid),
    .i_tail      (r_tail),
    .i_word_addr (cpu_addr[AW-1:2]),
    .o_hit       (w_hit),
    .o_hit_data  (w_hit_data)
  );

  assign cpu_rdata = w_hit ? w_hit_data : mem_rdata;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;
  assign mem_req   = ~w_empty;
  assign mem_addr  = r_entry[r_head].addr;
  assign mem_wdata = r_entry[r_head].data;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a vector table plus hand-written
// sequences for overflow, drain order and asynchronous reset mid-drain.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        full;
  logic        empty;
  logic [2:0]  count;
  logic        overflow;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int n_vec = 0;
  int n_bad = 0;

  store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Inputs for one cycle, plus the outputs expected before that cycle's rising edge.
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] mrd;
    logic [31:0] cnt;
    logic        req;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic ack, input logic [31:0] mrd, input logic [31:0] cnt,
                     input logic req, input logic [31:0] maddr, input logic [31:0] mwd,
                     input logic [31:0] rdata);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.ack = ack; v.mrd = mrd;
    v.cnt = cnt; v.req = req; v.maddr = maddr; v.mwd = mwd; v.rdata = rdata;
    vecs.push_back(v);
  endtask

  // Inputs are driven at the falling edge and outputs sampled 1 time unit later.
  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic ack, input logic [31:0] mrd);
    @(negedge clk);
    cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; mem_ack = ack; mem_rdata = mrd;
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_empty"}, 32'(empty), 32'd1);
    check({tag, "_full"},  32'(full), 32'd0);
    check({tag, "_req"},   32'(mem_req), 32'd0);
    check({tag, "_maddr"}, mem_addr, 32'd0);
    check({tag, "_mwdata"}, mem_wdata, 32'd0);
    check({tag, "_ovf"},   32'(overflow), 32'd0);
  endtask

  initial begin
    // Columns: we addr wdata ack mem_rdata | count req mem_addr mem_wdata cpu_rdata
    // Single store of 1024 to 0xFC4; ack held low for 3 cycles, then pulsed.
    add(1, 32'hFC4, 32'd1024, 0, 32'h0,  0, 0, 32'h0,   32'd0,    32'h0);
    add(0, 32'hFC4, 32'd0,    0, 32'h55, 1, 1, 32'hFC4, 32'd1024, 32'd1024);
    add(0, 32'hFC4, 32'd0,    0, 32'h55, 1, 1, 32'hFC4, 32'd1024, 32'd1024);
    add(0, 32'hFC4, 32'd0,    0, 32'h55, 1, 1, 32'hFC4, 32'd1024, 32'd1024);
    add(0, 32'hFC4, 32'd0,    1, 32'h55, 1, 1, 32'hFC4, 32'd1024, 32'd1024);
    add(0, 32'hFC4, 32'd0,    0, 32'h55, 0, 0, 32'h0,   32'd0,    32'h55);
    // Store 7 to 0x64; the load forwards it until the drain, then reads memory.
    add(1, 32'h64, 32'd7, 0, 32'h0,    0, 0, 32'h0,  32'd0, 32'h0);
    add(0, 32'h64, 32'd0, 0, 32'h0,    1, 1, 32'h64, 32'd7, 32'd7);
    add(0, 32'h64, 32'd0, 1, 32'h0,    1, 1, 32'h64, 32'd7, 32'd7);
    add(0, 32'h64, 32'd0, 0, 32'h1234, 0, 0, 32'h0,  32'd0, 32'h1234);
    // Stores of 5 and then 9 to 0x20; the younger store wins, including a load at 0x22.
    add(1, 32'h20, 32'd5, 0, 32'hAA, 0, 0, 32'h0,  32'd0, 32'hAA);
    add(1, 32'h20, 32'd9, 0, 32'hAA, 1, 1, 32'h20, 32'd5, 32'd5);
    add(0, 32'h20, 32'd0, 0, 32'hAA, 2, 1, 32'h20, 32'd5, 32'd9);
    add(0, 32'h22, 32'd0, 0, 32'hAA, 2, 1, 32'h20, 32'd5, 32'd9);
    // With count = 2, a push and a pop land on the same edge and the head wraps past DEPTH-1.
    add(1, 32'h30, 32'h33, 1, 32'hAA, 2, 1, 32'h20, 32'd5,  32'hAA);
    add(1, 32'h40, 32'h44, 1, 32'hAA, 2, 1, 32'h20, 32'd9,  32'hAA);
    add(0, 32'h30, 32'h0,  0, 32'hAA, 2, 1, 32'h30, 32'h33, 32'h33);
    add(0, 32'h40, 32'h0,  1, 32'hAA, 2, 1, 32'h30, 32'h33, 32'h44);
    add(0, 32'h20, 32'h0,  1, 32'hAA, 1, 1, 32'h40, 32'h44, 32'hAA);
    // An ack while the buffer is empty is ignored, so count does not underflow.
    add(0, 32'h0, 32'h0, 1, 32'hAA, 0, 0, 32'h0, 32'h0, 32'hAA);
    add(0, 32'h0, 32'h0, 0, 32'hAA, 0, 0, 32'h0, 32'h0, 32'hAA);

    // Reset state.
    #1;
    check_reset_values("rst0");
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].ack, vecs[i].mrd);
      check($sformatf("v%0d_count", i), 32'(count), vecs[i].cnt);
      check($sformatf("v%0d_empty", i), 32'(empty), 32'(vecs[i].cnt == 0));
      check($sformatf("v%0d_full", i),  32'(full), 32'(vecs[i].cnt == 4));
      check($sformatf("v%0d_req", i),   32'(mem_req), 32'(vecs[i].req));
      check($sformatf("v%0d_rdata", i), cpu_rdata, vecs[i].rdata);
      if (vecs[i].req) begin
        check($sformatf("v%0d_maddr", i), mem_addr, vecs[i].maddr);
        check($sformatf("v%0d_mwdata", i), mem_wdata, vecs[i].mwd);
      end
      check($sformatf("v%0d_ovf", i), 32'(overflow), 32'd0);
    end

    // Five back-to-back stores with no ack: the fifth is dropped and overflow is set.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(i * 4), 32'(100 + i), 1'b0, 32'hBEEF);
      if (i == 4) begin
        check("ovf_full_before5", 32'(full), 32'd1);
        check("ovf_count_before5", 32'(count), 32'd4);
      end
    end
    drive(1'b0, 32'h10, 32'h0, 1'b0, 32'hBEEF);
    check("ovf_count_after", 32'(count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_dropped_not_fwd", cpu_rdata, 32'hBEEF);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
      check($sformatf("drain%0d_req", k), 32'(mem_req), 32'd1);
      check($sformatf("drain%0d_addr", k), mem_addr, 32'(k * 4));
      check($sformatf("drain%0d_data", k), mem_wdata, 32'(100 + k));
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    check("drain_empty", 32'(empty), 32'd1);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Three entries buffered, then an asynchronous reset in the middle of the cycle.
    drive(1'b1, 32'h100, 32'h1, 1'b0, 32'h0);
    drive(1'b1, 32'h104, 32'h2, 1'b0, 32'h0);
    drive(1'b1, 32'h108, 32'h3, 1'b0, 32'h0);
    drive(1'b0, 32'h0,   32'h0, 1'b0, 32'h0);
    check("pre_rst_count", 32'(count), 32'd3);
    check("pre_rst_req", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async_rst");
    mem_ack = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("post_rst%0d_req", k), 32'(mem_req), 32'd0);
      check($sformatf("post_rst%0d_count", k), 32'(count), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
